bram_resp_ctrl: RTL and testbench

Responder end of the arbiter→BRAM request interface. It accepts one request per cycle (write or read), owns a single-port word memory, and returns read data after exactly DELAYS cycles. Returned data is steered to either the CPU or the DMA read-return port according to the reader select captured with the request. One instance serves u0; u1 uses the same block with reader select tied to 0.

---
 rtl/bram_resp_ctrl.sv | 156 +++++++++++++++
 tb/tb_bram_resp_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/bram_resp_ctrl.sv
// bram_resp_ctrl: responder end of the arbiter->BRAM request interface.
// Owns a single-port 32-bit word memory, accepts one request per cycle and
// returns read data after exactly DELAYS cycles, steered to the CPU or DMA
// return port by the reader select captured with the request.
// Optional feature macro: BRAM_RESP_PARITY_EN (even parity per stored word,
// adds the parity_err output).
module bram_resp_ctrl #(
  parameter int ADDR_W = 13,
  parameter int DEPTH  = 8192,
  parameter int DELAYS = 10
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n_i,
  input  logic              bram_wr,
  input  logic              bram_in_valid,
  input  logic [ADDR_W-1:0] bram_addr,
  input  logic [31:0]       bram_data_in,
  input  logic              bram_reader_sel,
  output logic              cpu_rd_valid,
  output logic [31:0]       cpu_rd_data,
  output logic              dma_rd_valid,
  output logic [31:0]       dma_rd_data,
  output logic [4:0]        rd_pending,
`ifdef BRAM_RESP_PARITY_EN
  output logic              parity_err,
`endif
  output logic              addr_err
);

  localparam int unsigned     MEM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

  logic [31:0]       mem [DEPTH];
  logic [MEM_AW-1:0] mem_idx;
  logic              in_range;
  logic              rd_acc;
  logic              wr_acc;
  logic [31:0]       rd_word;

  // Value leaving the delay line this cycle, loaded into the output registers.
  logic              ret_v;
  logic              ret_sel;
  logic [31:0]       ret_data;

`ifdef BRAM_RESP_PARITY_EN
  logic              mem_par [DEPTH];
  logic              rd_perr;
  logic              ret_perr;
`endif

  assign mem_idx = bram_addr[MEM_AW-1:0];

  // Request decode and asynchronous memory sample; out-of-range reads yield 0.
  always_comb begin
    in_range = ({1'b0, bram_addr} < DEPTH_X);
    rd_acc   = bram_in_valid & ~bram_wr;
    wr_acc   = bram_in_valid & bram_wr & in_range & wb_rst_n_i;
    rd_word  = in_range ? mem[mem_idx] : '0;
`ifdef BRAM_RESP_PARITY_EN
    rd_perr  = in_range & (mem_par[mem_idx] ^ (^mem[mem_idx]));
`endif
  end

  // Memory write port; contents deliberately survive reset.
  always_ff @(posedge wb_clk_i) begin
    if (wr_acc) begin
      mem[mem_idx] <= bram_data_in;
`ifdef BRAM_RESP_PARITY_EN
      mem_par[mem_idx] <= ^bram_data_in;
`endif
    end
  end

  // The output registers form the last latency stage, so the delay line
  // holds DELAYS-1 stages; with DELAYS=1 the capture feeds them directly.
  if (DELAYS == 1) begin : g_direct
    // Return the sampled word on the very next edge.
    always_comb begin
      ret_v    = rd_acc;
      ret_sel  = bram_reader_sel;
      ret_data = rd_word;
`ifdef BRAM_RESP_PARITY_EN
      ret_perr = rd_perr;
`endif
    end
  end else begin : g_pipe
    logic        pipe_v    [DELAYS-1];
    logic        pipe_sel  [DELAYS-1];
    logic [31:0] pipe_data [DELAYS-1];
`ifdef BRAM_RESP_PARITY_EN
    logic        pipe_perr [DELAYS-1];
`endif

    // Shift {valid, reader_sel, data} one stage per cycle; reset kills valids.
    always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_n_i) begin
        for (int unsigned i = 0; i < DELAYS - 1; i++) pipe_v[i] <= 1'b0;
      end else begin
        pipe_v[0]    <= rd_acc;
        pipe_sel[0]  <= bram_reader_sel;
        pipe_data[0] <= rd_word;
`ifdef BRAM_RESP_PARITY_EN
        pipe_perr[0] <= rd_perr;
`endif
        for (int unsigned i = 1; i < DELAYS - 1; i++) begin
          pipe_v[i]    <= pipe_v[i-1];
          pipe_sel[i]  <= pipe_sel[i-1];
          pipe_data[i] <= pipe_data[i-1];
`ifdef BRAM_RESP_PARITY_EN
          pipe_perr[i] <= pipe_perr[i-1];
`endif
        end
      end
    end

    // Tap the final delay stage.
    always_comb begin
      ret_v    = pipe_v[DELAYS-2];
      ret_sel  = pipe_sel[DELAYS-2];
      ret_data = pipe_data[DELAYS-2];
`ifdef BRAM_RESP_PARITY_EN
      ret_perr = pipe_perr[DELAYS-2];
`endif
    end
  end

  // Registered return ports, in-flight read counter and sticky address error.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      cpu_rd_valid <= 1'b0;
      dma_rd_valid <= 1'b0;
      cpu_rd_data  <= '0;
      dma_rd_data  <= '0;
      rd_pending   <= '0;
      addr_err     <= 1'b0;
`ifdef BRAM_RESP_PARITY_EN
      parity_err   <= 1'b0;
`endif
    end else begin
      cpu_rd_valid <= ret_v & ret_sel;
      dma_rd_valid <= ret_v & ~ret_sel;
      if (ret_v & ret_sel)  cpu_rd_data <= ret_data;
      if (ret_v & ~ret_sel) dma_rd_data <= ret_data;
`ifdef BRAM_RESP_PARITY_EN
      parity_err   <= ret_v & ret_perr;
`endif
      case ({rd_acc, ret_v})
        2'b10:   rd_pending <= rd_pending + 5'd1;
        2'b01:   rd_pending <= rd_pending - 5'd1;
        default: rd_pending <= rd_pending;
      endcase
      if (bram_in_valid & ~in_range) addr_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bram_resp_ctrl.sv
// tb_bram_resp_ctrl: directed bench for bram_resp_ctrl (DEPTH=4096, DELAYS=10).
module tb_bram_resp_ctrl;

  localparam int D = 10;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_n_i;
  logic        bram_wr;
  logic        bram_in_valid;
  logic [12:0] bram_addr;
  logic [31:0] bram_data_in;
  logic        bram_reader_sel;
  logic        cpu_rd_valid;
  logic [31:0] cpu_rd_data;
  logic        dma_rd_valid;
  logic [31:0] dma_rd_data;
  logic [4:0]  rd_pending;
  logic        addr_err;
`ifdef BRAM_RESP_PARITY_EN
  logic        parity_err;
`endif

  int total = 0;
  int bad   = 0;

  bram_resp_ctrl #(
    .ADDR_W (13),
    .DEPTH  (4096),
    .DELAYS (D)
  ) dut (
    .wb_clk_i        (wb_clk_i),
    .wb_rst_n_i      (wb_rst_n_i),
    .bram_wr         (bram_wr),
    .bram_in_valid   (bram_in_valid),
    .bram_addr       (bram_addr),
    .bram_data_in    (bram_data_in),
    .bram_reader_sel (bram_reader_sel),
    .cpu_rd_valid    (cpu_rd_valid),
    .cpu_rd_data     (cpu_rd_data),
    .dma_rd_valid    (dma_rd_valid),
    .dma_rd_data     (dma_rd_data),
    .rd_pending      (rd_pending),
`ifdef BRAM_RESP_PARITY_EN
    .parity_err      (parity_err),
`endif
    .addr_err        (addr_err)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  // Present one request for exactly one edge.
  task automatic issue(input logic w, input logic [12:0] a, input logic [31:0] d, input logic s);
    bram_in_valid   = 1'b1;
    bram_wr         = w;
    bram_addr       = a;
    bram_data_in    = d;
    bram_reader_sel = s;
    tick();
    bram_in_valid   = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    wb_rst_n_i = 1'b0;
    for (int i = 0; i < cycles; i++) tick();
    wb_rst_n_i = 1'b1;
  endtask

  initial begin
    wb_rst_n_i = 1'b0; bram_wr = 1'b0; bram_in_valid = 1'b0;
    bram_addr = '0; bram_data_in = '0; bram_reader_sel = 1'b0;
    do_reset(2);

    // Reset state
    check("rst_cpu_v",  cpu_rd_valid, 0);
    check("rst_dma_v",  dma_rd_valid, 0);
    check("rst_cpu_d",  cpu_rd_data,  0);
    check("rst_dma_d",  dma_rd_data,  0);
    check("rst_pend",   rd_pending,   0);
    check("rst_aerr",   addr_err,     0);

    // Memory retained across reset; CPU return after DELAYS
    issue(1'b1, 13'd5, 32'hDEADBEEF, 1'b0);
    do_reset(2);
    issue(1'b0, 13'd5, 32'h0, 1'b1);
    check("ret_pend1", rd_pending, 1);
    for (int k = 1; k <= D - 2; k++) begin
      tick();
      check("ret_early_v", {cpu_rd_valid, dma_rd_valid}, 0);
    end
    tick();
    check("ret_cpu_v",  cpu_rd_valid, 1);
    check("ret_cpu_d",  cpu_rd_data,  32'hDEADBEEF);
    check("ret_dma_v",  dma_rd_valid, 0);
    check("ret_pend0",  rd_pending,   0);
    tick();
    check("ret_drop_v", cpu_rd_valid, 0);
    check("ret_hold_d", cpu_rd_data,  32'hDEADBEEF);

    // Streaming reads, alternating destination
    for (int i = 0; i < 8; i++) issue(1'b1, 13'(i), 32'h100 + 32'(i), 1'b0);
    for (int i = 0; i < 8; i++) begin
      bram_in_valid = 1'b1; bram_wr = 1'b0;
      bram_addr = 13'(i); bram_reader_sel = (i % 2 == 1);
      tick();
    end
    bram_in_valid = 1'b0;
    check("str_pend_pk", rd_pending, 8);
    tick();
    check("str_gap_v", {cpu_rd_valid, dma_rd_valid}, 0);
    check("str_pend_pk2", rd_pending, 8);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i % 2 == 1) begin
        check("str_cpu_v", {cpu_rd_valid, dma_rd_valid}, 2'b10);
        check("str_cpu_d", cpu_rd_data, 32'h100 + 32'(i));
      end else begin
        check("str_dma_v", {cpu_rd_valid, dma_rd_valid}, 2'b01);
        check("str_dma_d", dma_rd_data, 32'h100 + 32'(i));
      end
      check("str_pend", rd_pending, 5'(7 - i));
    end
    tick();
    check("str_end_v", {cpu_rd_valid, dma_rd_valid}, 0);

    // Idle cycle with garbage must not write
    bram_in_valid = 1'b0; bram_wr = 1'b1; bram_addr = 13'd6; bram_data_in = 32'hBADBAD00;
    tick();
    issue(1'b0, 13'd6, 32'h0, 1'b0);
    for (int k = 1; k <= D - 1; k++) tick();
    check("idle_dma_v", dma_rd_valid, 1);
    check("idle_dma_d", dma_rd_data,  32'h106);

    // Read-after-write
    issue(1'b1, 13'd20, 32'hAAAA5555, 1'b0);
    issue(1'b1, 13'd20, 32'h12345678, 1'b0);
    issue(1'b0, 13'd20, 32'h0, 1'b1);
    for (int k = 1; k <= D - 1; k++) tick();
    check("raw_cpu_v", cpu_rd_valid, 1);
    check("raw_cpu_d", cpu_rd_data,  32'h12345678);

    // Mid-flight reset discards in-flight reads
    for (int i = 0; i < 4; i++) issue(1'b0, 13'(i), 32'h0, (i % 2 == 1));
    check("mfr_pend4", rd_pending, 4);
    for (int k = 0; k < 3; k++) tick();
    do_reset(2);
    check("mfr_pend0", rd_pending,  0);
    check("mfr_cpu_d", cpu_rd_data, 0);
    for (int k = 0; k < 15; k++) begin
      tick();
      check("mfr_no_v", {cpu_rd_valid, dma_rd_valid}, 0);
    end

    // Out of range: 5000 >= 4096; must not alias onto 904
    check("oor_aerr0", addr_err, 0);
    issue(1'b1, 13'd904, 32'h00000055, 1'b0);
    issue(1'b1, 13'd5000, 32'hFFFFFFFF, 1'b0);
    check("oor_aerr1", addr_err, 1);
    issue(1'b0, 13'd904, 32'h0, 1'b1);
    issue(1'b0, 13'd5000, 32'h0, 1'b1);
    for (int k = 1; k <= D - 2; k++) tick();
    check("oor_alias_v", cpu_rd_valid, 1);
    check("oor_alias_d", cpu_rd_data,  32'h55);
    tick();
    check("oor_rd_v", cpu_rd_valid, 1);
    check("oor_rd_d", cpu_rd_data,  32'h0);
    for (int k = 0; k < 5; k++) tick();
    check("oor_sticky", addr_err, 1);
    do_reset(1);
    check("oor_clr", addr_err, 0);

`ifdef BRAM_RESP_PARITY_EN
    // Corrupt stored word 3 (0x103) behind the parity bit
    dut.mem[3] = dut.mem[3] ^ 32'h1;
    issue(1'b0, 13'd3, 32'h0, 1'b0);
    for (int k = 1; k <= D - 2; k++) begin
      tick();
      check("par_early", parity_err, 0);
    end
    tick();
    check("par_v",   dma_rd_valid, 1);
    check("par_d",   dma_rd_data,  32'h102);
    check("par_err", parity_err,   1);
    tick();
    check("par_pulse", parity_err, 0);
    issue(1'b0, 13'd4, 32'h0, 1'b0);
    for (int k = 1; k <= D - 1; k++) tick();
    check("par_ok_v",   dma_rd_valid, 1);
    check("par_ok_d",   dma_rd_data,  32'h104);
    check("par_ok_err", parity_err,   0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
